// File: rtl/osc_seq_pkg.sv
// Shared types and constants for the oscillator note sequencer.
package osc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int SEL_W = 3;

  // Waveform codes understood by the oscillator output mux.
  localparam logic [SEL_W-1:0] SEL_SINE     = 3'd0;
  localparam logic [SEL_W-1:0] SEL_SQUARE   = 3'd1;
  localparam logic [SEL_W-1:0] SEL_SAW      = 3'd2;
  localparam logic [SEL_W-1:0] SEL_TRIANGLE = 3'd3;
  localparam logic [SEL_W-1:0] SEL_NOISE    = 3'd4;

  // A pattern entry is packed as {tuning, sel, dur}, with dur in the low bits.
  function automatic int entry_width(input int tune_w, input int dur_w);
    return tune_w + SEL_W + dur_w;
  endfunction

endpackage

// File: rtl/osc_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles; clr restarts the count.
module osc_tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = !clr && (cnt == LAST);

  // Free-running 0..TICK_DIV-1 counter, forced to zero while cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/osc_note_sequencer.sv
// Step sequencer driving one oscillator's tuning word, waveform select and
// phase-accumulator enable from a small programmable note pattern.
module osc_note_sequencer
  import osc_seq_pkg::*;
#(
  parameter int tune      = 16,
  parameter int STEPS     = 8,
  parameter int DUR_W     = 8,
  parameter int TICK_DIV  = 50000,
  parameter int GAP_TICKS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(STEPS)-1:0]   wr_addr,
  input  logic [tune-1:0]            wr_tuning,
  input  logic [2:0]                 wr_sel,
  input  logic [DUR_W-1:0]           wr_dur,
  input  logic [$clog2(STEPS):0]     seq_len,
  input  logic                       loop,
  input  logic                       start,
  input  logic                       stop,
  output logic [tune-1:0]            tuningW,
  output logic [2:0]                 sel,
  output logic                       CE,
  output logic                       busy,
  output logic [$clog2(STEPS)-1:0]   step_idx,
  output logic                       step_strobe
);

  localparam int IW = $clog2(STEPS);
  localparam int LW = IW + 1;
  localparam int EW = entry_width(tune, DUR_W);
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [LW-1:0] STEPS_L  = LW'(STEPS);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  logic [EW-1:0] pattern [STEPS];

  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [LW-1:0]    len, len_n;
  logic             loop_q, loop_n;
  logic [DUR_W-1:0] dur_cnt, dur_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic [tune-1:0]  tuning_q, tuning_n;
  logic [2:0]       sel_q, sel_n;
  logic             ce_q, ce_n;
  logic             strobe_q, strobe_n;
  logic             busy_q, busy_n;

  logic             tick;
  logic             clr;
  logic             adv;
  logic             not_last;
  logic             len_ok;
  logic [EW-1:0]    entry;
  logic [tune-1:0]  e_tune;
  logic [2:0]       e_sel;
  logic [DUR_W-1:0] e_dur;

  assign entry    = pattern[idx];
  assign e_dur    = entry[DUR_W-1:0];
  assign e_sel    = entry[DUR_W +: SEL_W];
  assign e_tune   = entry[DUR_W + SEL_W +: tune];
  assign not_last = ({1'b0, idx} + LW'(1)) < len;
  assign len_ok   = (seq_len != '0) && (seq_len <= STEPS_L);
  assign clr      = (state == IDLE) || (state == LOAD);

  osc_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  // Pattern storage: host writes land at the next edge in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) begin
        pattern[i] <= '0;
      end
    end else if (wr_en) begin
      pattern[wr_addr] <= {wr_tuning, wr_sel, wr_dur};
    end
  end

  // Next-state and next-output logic; stop beats start, start restarts from entry 0.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    len_n    = len;
    loop_n   = loop_q;
    dur_n    = dur_cnt;
    gap_n    = gap_cnt;
    tuning_n = tuning_q;
    sel_n    = sel_q;
    ce_n     = ce_q;
    strobe_n = 1'b0;
    adv      = 1'b0;

    unique case (state)
      IDLE: begin
        state_n = IDLE;
      end
      LOAD: begin
        if (e_dur != '0) begin
          tuning_n = e_tune;
          sel_n    = e_sel;
          ce_n     = 1'b1;
          strobe_n = 1'b1;
          dur_n    = e_dur;
          state_n  = PLAY;
        end else begin
          adv = 1'b1;
        end
      end
      PLAY: begin
        if (tick) begin
          if (dur_cnt <= DUR_W'(1)) begin
            dur_n = '0;
            if (GAP_TICKS > 0) begin
              ce_n    = 1'b0;
              gap_n   = '0;
              state_n = GAP;
            end else begin
              adv = 1'b1;
            end
          end else begin
            dur_n = dur_cnt - 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt >= GAP_LAST) begin
            adv = 1'b1;
          end else begin
            gap_n = gap_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (adv) begin
      if (not_last) begin
        idx_n   = idx + 1'b1;
        state_n = LOAD;
      end else if (loop_q) begin
        idx_n   = '0;
        state_n = LOAD;
      end else begin
        ce_n    = 1'b0;
        state_n = IDLE;
      end
    end

    if (stop) begin
      state_n  = IDLE;
      ce_n     = 1'b0;
      strobe_n = 1'b0;
      tuning_n = tuning_q;
      sel_n    = sel_q;
    end else if (start && len_ok) begin
      state_n  = LOAD;
      idx_n    = '0;
      len_n    = seq_len;
      loop_n   = loop;
      tuning_n = tuning_q;
      sel_n    = sel_q;
      ce_n     = ce_q;
      strobe_n = 1'b0;
    end

    busy_n = (state_n != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      len      <= '0;
      loop_q   <= 1'b0;
      dur_cnt  <= '0;
      gap_cnt  <= '0;
      tuning_q <= '0;
      sel_q    <= '0;
      ce_q     <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      len      <= len_n;
      loop_q   <= loop_n;
      dur_cnt  <= dur_n;
      gap_cnt  <= gap_n;
      tuning_q <= tuning_n;
      sel_q    <= sel_n;
      ce_q     <= ce_n;
      strobe_q <= strobe_n;
      busy_q   <= busy_n;
    end
  end

  assign tuningW     = tuning_q;
  assign sel         = sel_q;
  assign CE          = ce_q;
  assign busy        = busy_q;
  assign step_idx    = idx;
  assign step_strobe = strobe_q;

endmodule

// File: tb/tb_osc_note_sequencer.sv
// Directed, table-driven bench for osc_note_sequencer (TICK_DIV=4, GAP_TICKS=1, STEPS=8).
module tb_osc_note_sequencer;
  import osc_seq_pkg::*;

  // One expected-output snapshot, taken n cycles after the edge that sampled start.
  typedef struct {
    int          n;
    logic        busy;
    logic        ce;
    logic        strobe;
    logic [15:0] tuning;
    logic [2:0]  sel;
    logic [2:0]  idx;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_tuning = '0;
  logic [2:0]  wr_sel = '0;
  logic [7:0]  wr_dur = '0;
  logic [3:0]  seq_len = '0;
  logic        loop = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] tuning_w;
  logic [2:0]  sel;
  logic        ce;
  logic        busy;
  logic [2:0]  step_idx;
  logic        step_strobe;

  int   total = 0;
  int   bad = 0;
  int   cur = 0;
  int   ce_count = 0;
  int   strobe_count = 0;
  vec_t vecs[$];

  osc_note_sequencer #(
    .tune      (16),
    .STEPS     (8),
    .DUR_W     (8),
    .TICK_DIV  (4),
    .GAP_TICKS (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_tuning   (wr_tuning),
    .wr_sel      (wr_sel),
    .wr_dur      (wr_dur),
    .seq_len     (seq_len),
    .loop        (loop),
    .start       (start),
    .stop        (stop),
    .tuningW     (tuning_w),
    .sel         (sel),
    .CE          (ce),
    .busy        (busy),
    .step_idx    (step_idx),
    .step_strobe (step_strobe)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
    if (ce) ce_count++;
    if (step_strobe) strobe_count++;
    cur++;
  endtask

  task automatic stepTo(input int n);
    while (cur < n) cycle();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic writeEntry(input logic [2:0] a, input logic [15:0] t, input logic [2:0] s, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_tuning = t;
    wr_sel = s;
    wr_dur = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] len, input logic lp);
    seq_len = len;
    loop = lp;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cur = 0;
    ce_count = 0;
    strobe_count = 0;
  endtask

  task automatic pulseStop();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  task automatic addVec(input int n, input logic b, input logic c, input logic s,
                        input logic [15:0] t, input logic [2:0] sl, input logic [2:0] i);
    vec_t v;
    v.n = n; v.busy = b; v.ce = c; v.strobe = s; v.tuning = t; v.sel = sl; v.idx = i;
    vecs.push_back(v);
  endtask

  task automatic runTable(input string tag);
    foreach (vecs[i]) begin
      stepTo(vecs[i].n);
      checkOutput($sformatf("%s n%0d busy", tag, vecs[i].n), 32'(busy), 32'(vecs[i].busy));
      checkOutput($sformatf("%s n%0d CE", tag, vecs[i].n), 32'(ce), 32'(vecs[i].ce));
      checkOutput($sformatf("%s n%0d strobe", tag, vecs[i].n), 32'(step_strobe), 32'(vecs[i].strobe));
      checkOutput($sformatf("%s n%0d tuningW", tag, vecs[i].n), 32'(tuning_w), 32'(vecs[i].tuning));
      checkOutput($sformatf("%s n%0d sel", tag, vecs[i].n), 32'(sel), 32'(vecs[i].sel));
      checkOutput($sformatf("%s n%0d step_idx", tag, vecs[i].n), 32'(step_idx), 32'(vecs[i].idx));
    end
    vecs.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " tuningW"}, 32'(tuning_w), 32'h0);
    checkOutput({tag, " sel"}, 32'(sel), 32'h0);
    checkOutput({tag, " CE"}, 32'(ce), 32'h0);
    checkOutput({tag, " busy"}, 32'(busy), 32'h0);
    checkOutput({tag, " step_idx"}, 32'(step_idx), 32'h0);
    checkOutput({tag, " strobe"}, 32'(step_strobe), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    cycle();

    // Two-note one-shot: e0 sounds 8 cycles, gap + reload, e1 sounds 4 cycles, then idle.
    writeEntry(3'd0, 16'h1000, SEL_SQUARE, 8'd2);
    writeEntry(3'd1, 16'h2000, SEL_TRIANGLE, 8'd1);
    applyStimulus(4'd2, 1'b0);
    addVec(0,  1, 0, 0, 16'h0000, 3'd0, 3'd0);
    addVec(1,  1, 1, 1, 16'h1000, 3'd1, 3'd0);
    addVec(2,  1, 1, 0, 16'h1000, 3'd1, 3'd0);
    addVec(8,  1, 1, 0, 16'h1000, 3'd1, 3'd0);
    addVec(9,  1, 0, 0, 16'h1000, 3'd1, 3'd0);
    addVec(13, 1, 0, 0, 16'h1000, 3'd1, 3'd1);
    addVec(14, 1, 1, 1, 16'h2000, 3'd3, 3'd1);
    addVec(17, 1, 1, 0, 16'h2000, 3'd3, 3'd1);
    addVec(18, 1, 0, 0, 16'h2000, 3'd3, 3'd1);
    addVec(21, 1, 0, 0, 16'h2000, 3'd3, 3'd1);
    addVec(22, 0, 0, 0, 16'h2000, 3'd3, 3'd1);
    runTable("oneshot");
    checkOutput("oneshot CE cycles", 32'(ce_count), 32'd12);
    checkOutput("oneshot strobes", 32'(strobe_count), 32'd2);

    // Zero-duration entry is skipped with no strobe and no extra silence beyond its LOAD.
    writeEntry(3'd1, 16'h2000, SEL_TRIANGLE, 8'd0);
    writeEntry(3'd2, 16'h3000, SEL_SAW, 8'd1);
    applyStimulus(4'd3, 1'b0);
    addVec(0,  1, 0, 0, 16'h2000, 3'd3, 3'd0);
    addVec(1,  1, 1, 1, 16'h1000, 3'd1, 3'd0);
    addVec(9,  1, 0, 0, 16'h1000, 3'd1, 3'd0);
    addVec(13, 1, 0, 0, 16'h1000, 3'd1, 3'd1);
    addVec(14, 1, 0, 0, 16'h1000, 3'd1, 3'd2);
    addVec(15, 1, 1, 1, 16'h3000, 3'd2, 3'd2);
    addVec(18, 1, 1, 0, 16'h3000, 3'd2, 3'd2);
    addVec(19, 1, 0, 0, 16'h3000, 3'd2, 3'd2);
    addVec(22, 1, 0, 0, 16'h3000, 3'd2, 3'd2);
    addVec(23, 0, 0, 0, 16'h3000, 3'd2, 3'd2);
    runTable("skip");
    checkOutput("skip CE cycles", 32'(ce_count), 32'd12);
    checkOutput("skip strobes", 32'(strobe_count), 32'd2);

    // Restart while busy: a second start returns to entry 0 and reloads it.
    writeEntry(3'd1, 16'h2000, SEL_TRIANGLE, 8'd1);
    applyStimulus(4'd2, 1'b0);
    stepTo(15);
    checkOutput("restart pre tuningW", 32'(tuning_w), 32'h2000);
    applyStimulus(4'd2, 1'b0);
    checkOutput("restart n0 busy", 32'(busy), 32'd1);
    checkOutput("restart n0 step_idx", 32'(step_idx), 32'd0);
    stepTo(1);
    checkOutput("restart n1 tuningW", 32'(tuning_w), 32'h1000);
    checkOutput("restart n1 strobe", 32'(step_strobe), 32'd1);
    stepTo(22);
    checkOutput("restart end busy", 32'(busy), 32'd0);

    // Looping: after e1's gap the pattern wraps to entry 0; stop in PLAY exits in one edge.
    applyStimulus(4'd2, 1'b1);
    addVec(1,  1, 1, 1, 16'h1000, 3'd1, 3'd0);
    addVec(13, 1, 0, 0, 16'h1000, 3'd1, 3'd1);
    addVec(14, 1, 1, 1, 16'h2000, 3'd3, 3'd1);
    addVec(21, 1, 0, 0, 16'h2000, 3'd3, 3'd1);
    addVec(22, 1, 0, 0, 16'h2000, 3'd3, 3'd0);
    addVec(23, 1, 1, 1, 16'h1000, 3'd1, 3'd0);
    addVec(24, 1, 1, 0, 16'h1000, 3'd1, 3'd0);
    runTable("loop");
    pulseStop();
    checkOutput("stop CE", 32'(ce), 32'd0);
    checkOutput("stop busy", 32'(busy), 32'd0);
    checkOutput("stop tuningW held", 32'(tuning_w), 32'h1000);
    checkOutput("stop sel held", 32'(sel), 32'd1);

    // Rewriting the sounding entry only shows up when that entry is next loaded.
    applyStimulus(4'd2, 1'b1);
    stepTo(3);
    writeEntry(3'd0, 16'h1111, SEL_SQUARE, 8'd2);
    stepTo(5);
    checkOutput("live write n5 tuningW", 32'(tuning_w), 32'h1000);
    checkOutput("live write n5 CE", 32'(ce), 32'd1);
    stepTo(23);
    checkOutput("live write n23 tuningW", 32'(tuning_w), 32'h1111);
    checkOutput("live write n23 strobe", 32'(step_strobe), 32'd1);
    pulseStop();

    // start and stop together while busy: stop wins.
    applyStimulus(4'd2, 1'b1);
    stepTo(5);
    start = 1'b1;
    stop = 1'b1;
    cycle();
    start = 1'b0;
    stop = 1'b0;
    checkOutput("start+stop busy", 32'(busy), 32'd0);
    checkOutput("start+stop CE", 32'(ce), 32'd0);

    // Out-of-range lengths are ignored.
    applyStimulus(4'd0, 1'b0);
    checkOutput("len0 busy", 32'(busy), 32'd0);
    applyStimulus(4'd9, 1'b0);
    checkOutput("len9 busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-PLAY clears outputs immediately and wipes the pattern.
    applyStimulus(4'd2, 1'b1);
    stepTo(3);
    checkOutput("pre-reset CE", 32'(ce), 32'd1);
    rst_n = 1'b0;
    #1;
    checkAllZero("async reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(4'd2, 1'b0);
    stepTo(10);
    checkOutput("wiped CE cycles", 32'(ce_count), 32'd0);
    checkOutput("wiped strobes", 32'(strobe_count), 32'd0);
    checkOutput("wiped busy", 32'(busy), 32'd0);

    // All-zero pattern with loop keeps cycling through LOAD until stopped.
    applyStimulus(4'd2, 1'b1);
    stepTo(10);
    checkOutput("zero loop busy", 32'(busy), 32'd1);
    checkOutput("zero loop CE cycles", 32'(ce_count), 32'd0);
    checkOutput("zero loop strobes", 32'(strobe_count), 32'd0);
    pulseStop();
    checkOutput("zero loop stop busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/osc_note_sequencer.md
Name: osc_note_sequencer

Overview:
- Step sequencer that configures and sequences one oscillator: drives its tuning word, waveform select and phase-accumulator clock enable.
- Holds a small programmable pattern of note entries {tuning, sel, duration} and plays them in order, once or looping.
- An optional silent gap between notes freezes the phase accumulator.
- Sits between the host/config logic and the oscillator's tuningW/sel/CE inputs.

Parameters:
- tune, 16, tuning word width (matches oscillator).
- STEPS, 8, pattern entries (power of 2, >=2).
- DUR_W, 8, duration field width, in ticks.
- TICK_DIV, 50000, clk cycles per tick (>=2).
- GAP_TICKS, 1, silent ticks after each note (0 = legato).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- wr_en  in  1  pattern write strobe.
- wr_addr  in  clog2(STEPS)  entry index.
- wr_tuning  in  tune  entry tuning word.
- wr_sel  in  3  entry waveform select.
- wr_dur  in  DUR_W  entry duration in ticks; 0 = skip entry.
- seq_len  in  clog2(STEPS)+1  active entries; sampled on start.
- loop  in  1  repeat pattern; sampled on start.
- start  in  1  pulse: begin at entry 0.
- stop  in  1  pulse: abort to idle.
- tuningW  out  tune  to oscillator.
- sel  out  3  to oscillator.
- CE  out  1  to oscillator phase accumulator.
- busy  out  1  state != IDLE.
- step_idx  out  clog2(STEPS)  current entry.
- step_strobe  out  1  one-cycle pulse when an entry starts sounding.

Behaviour:
- Reset (async, rst_n=0): all pattern entries zeroed; tuningW=0, sel=0, CE=0, busy=0, step_idx=0, step_strobe=0; state IDLE; counters 0.
- Writes are accepted in any state, taking effect at the next clock edge. A write to the currently sounding entry does not change the outputs until that entry is next loaded.
- States are IDLE, LOAD, PLAY and GAP. All outputs are registered.
- IDLE:
  - start with seq_len!=0 and seq_len<=STEPS: latch len and loop, set idx=0, go to LOAD.
  - Otherwise start is ignored.
- LOAD (1 cycle), when entry.dur!=0:
  - tuningW and sel are set to the entry; CE=1; step_strobe=1.
  - dur_cnt=entry.dur; tick counter cleared; go to PLAY.
- LOAD, when entry.dur==0: advance immediately. CE keeps its prior value; no strobe.
- PLAY:
  - The tick counter counts 0..TICK_DIV-1; each wrap is one tick and decrements dur_cnt.
  - On the tick where dur_cnt reaches 0: go to GAP with CE=0 if GAP_TICKS>0, else advance.
  - CE is high for exactly dur*TICK_DIV cycles in the gap case.
- GAP: lasts GAP_TICKS*TICK_DIV cycles with CE=0 and tuningW/sel held, then advance.
- Advance:
  - If idx<len-1: idx+1, LOAD.
  - Else if loop: idx=0, LOAD.
  - Else: IDLE with CE=0.
- Latency: start sampled at edge k gives LOAD at edge k+1; CE/tuningW/step_strobe are visible after edge k+1.
- stop in any state: next edge goes to IDLE with CE=0 and busy=0; tuningW/sel hold their last value.
- stop and start in the same cycle: stop wins.
- start while busy: restart, i.e. re-latch len/loop, idx=0, go to LOAD.
- A pattern whose active entries all have dur=0: while loop=1 it cycles through LOAD states with CE unchanged; stop exits. The bench must not treat this as a hang.
- Arithmetic: dur_cnt is DUR_W bits, the tick counter is clog2(TICK_DIV) bits, the gap counter is clog2(GAP_TICKS+1) bits. Nothing wraps unguarded.

Decomposition:
- Package osc_seq_pkg holds:
  - the state enum (IDLE, LOAD, PLAY, GAP);
  - the entry field widths and the packed entry width (tune+3+DUR_W);
  - SEL_* waveform codes shared with the oscillator mux.
- Sub-module osc_tick_prescaler (TICK_DIV):
  - inputs clk, rst_n, clr;
  - output a one-cycle tick.
  - Cleared in LOAD; held cleared in IDLE.

Test Plan (TICK_DIV=4, GAP_TICKS=1, STEPS=8):
- Reset mid-PLAY (rst_n low for 1 cycle) -> all outputs 0 immediately, busy=0, and entries read back as zero on the next start (no CE).
- Write e0={0x1000,sel 1,dur 2}, e1={0x2000,sel 3,dur 1}, len=2, loop=0, start -> tuningW=0x1000 with CE=1 for 8 cycles, then CE=0 for 4, then 0x2000 with CE=1 for 4, CE=0 for 4, then IDLE; step_strobe pulses twice.
- Same pattern with loop=1 -> after e1's gap, step_idx=0 and tuningW=0x1000 again; stop during PLAY -> CE=0 and busy=0 one edge later.
- e1.dur=0, len=3, e2={0x3000,dur 1} -> e1 produces no strobe; e0's gap is followed directly by e2.
- start and stop asserted together while busy -> IDLE; start with seq_len=0 -> ignored, busy stays 0.
- Write to e0 while e0 is playing with loop=1 -> outputs unchanged until the next pass, which then shows the new tuning.
